// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction sequencer and its bench.
package instr_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Instruction field layout of the target CPU, used for decoding in benches.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_LSB  = 23;
  localparam int RS_LSB  = 19;
  localparam int RT_LSB  = 15;
  localparam int REG_W   = 4;

  function automatic logic [4:0] opcode_of(input logic [31:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_store.sv
// Programmable instruction store: one write port, one combinational read port, no reset.
module instr_store #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store write; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Replays a stored program into the CPU Instruction input, timed or fetch-paced,
// one-shot or looping, and captures one CPU result per executed instruction.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int HOLD_CYCLES = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
  input  logic              paced,
  input  logic              en_fetch_pulse,
  input  logic              en_exe_pulse,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] Instruction,
  output logic [ADDR_W-1:0] instr_idx,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              trace_valid,
  output logic [DATA_W-1:0] trace_data,
  output logic [ADDR_W-1:0] trace_idx
);

  localparam int LW    = ADDR_W + 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [LW-1:0]    DEPTH_L  = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic              loop_q, loop_d;
  logic              paced_q, paced_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              aborted_q, aborted_d;
  logic              tvalid_q;
  logic [DATA_W-1:0] tdata_q;
  logic [ADDR_W-1:0] tidx_q;

  logic              adv;
  logic              last;
  logic [LW-1:0]     eff_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // Loading is only honoured while idle, so a running program is never disturbed.
  instr_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk_i   (clk),
    .we_i    (load_en && (state_q == S_IDLE)),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign eff_len = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last    = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign adv     = paced_q ? en_fetch_pulse : (cnt_q == CNT_LAST);

  // Next-state logic; the read port always points at the word needed at the next advance.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    loop_d    = loop_q;
    paced_d   = paced_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    aborted_d = 1'b0;
    rd_addr   = '0;
    case (state_q)
      S_IDLE: begin
        if (start && (eff_len != '0)) begin
          state_d = S_HOLD;
          idx_d   = '0;
          len_d   = eff_len;
          loop_d  = loop_mode;
          paced_d = paced;
          cnt_d   = '0;
          instr_d = rd_data;
        end
      end
      S_HOLD: begin
        rd_addr = last ? '0 : idx_q + ADDR_W'(1);
        if (stop) begin
          state_d   = S_IDLE;
          idx_d     = '0;
          cnt_d     = '0;
          instr_d   = NOP_WORD;
          aborted_d = 1'b1;
        end else if (adv) begin
          cnt_d = '0;
          if (!last) begin
            idx_d   = idx_q + ADDR_W'(1);
            instr_d = rd_data;
          end else if (loop_q) begin
            idx_d   = '0;
            instr_d = rd_data;
          end else begin
            state_d = S_DONE;
            idx_d   = '0;
            instr_d = NOP_WORD;
          end
        end else if (!paced_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      paced_q   <= 1'b0;
      cnt_q     <= '0;
      instr_q   <= NOP_WORD;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      loop_q    <= loop_d;
      paced_q   <= paced_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      aborted_q <= aborted_d;
    end
  end

  // Result capture: an execute strobe during replay records the pre-advance index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tidx_q   <= '0;
    end else begin
      tvalid_q <= en_exe_pulse && (state_q == S_HOLD);
      if (en_exe_pulse && (state_q == S_HOLD)) begin
        tdata_q <= result;
        tidx_q  <= idx_q;
      end
    end
  end

  assign Instruction = instr_q;
  assign instr_idx   = idx_q;
  assign busy        = (state_q == S_HOLD);
  assign done        = (state_q == S_DONE);
  assign aborted     = aborted_q;
  assign trace_valid = tvalid_q;
  assign trace_data  = tdata_q;
  assign trace_idx   = tidx_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: vector table, directed corner cases,
// and randomized replays checked against a count/arithmetic based model.
module tb_instr_sequencer;
  import instr_seq_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int HOLD   = 4;
  localparam logic [31:0] NOP = 32'h0;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic [ADDR_W:0]   prog_len = '0;
  logic              start = 1'b0, stop = 1'b0, loop_mode = 1'b0, paced = 1'b0;
  logic              en_fetch_pulse = 1'b0, en_exe_pulse = 1'b0;
  logic [DATA_W-1:0] result = '0;
  logic [DATA_W-1:0] Instruction, trace_data;
  logic [ADDR_W-1:0] instr_idx, trace_idx;
  logic              busy, done, aborted, trace_valid;

  instr_sequencer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .stop(stop), .loop_mode(loop_mode), .paced(paced),
    .en_fetch_pulse(en_fetch_pulse), .en_exe_pulse(en_exe_pulse), .result(result),
    .Instruction(Instruction), .instr_idx(instr_idx), .busy(busy), .done(done),
    .aborted(aborted), .trace_valid(trace_valid), .trace_data(trace_data), .trace_idx(trace_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] mem [DEPTH];

  typedef struct {
    logic              start;
    logic [ADDR_W:0]   plen;
    logic              stop;
    logic [31:0]       e_instr;
    logic [ADDR_W-1:0] e_idx;
    logic              e_busy, e_done, e_ab;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_core(input string nm, input logic [31:0] e_instr, input int e_idx,
                          input logic e_busy, input logic e_done, input logic e_ab);
    chk({nm, ".instr"}, Instruction, e_instr);
    chk({nm, ".idx"}, 32'(instr_idx), 32'(e_idx));
    chk({nm, ".busy"}, 32'(busy), 32'(e_busy));
    chk({nm, ".done"}, 32'(done), 32'(e_done));
    chk({nm, ".aborted"}, 32'(aborted), 32'(e_ab));
  endtask

  task automatic chk_reset(input string nm);
    chk_core(nm, NOP, 0, 1'b0, 1'b0, 1'b0);
    chk({nm, ".tvalid"}, 32'(trace_valid), 32'h0);
    chk({nm, ".tdata"}, trace_data, 32'h0);
    chk({nm, ".tidx"}, 32'(trace_idx), 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; stop = 0; load_en = 0; en_fetch_pulse = 0; en_exe_pulse = 0;
    loop_mode = 0; paced = 0; result = '0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_en = 1; load_addr = ADDR_W'(a); load_data = d;
    step();
    load_en = 0;
    mem[a] = d;
  endtask

  task automatic do_start(input int len, input logic lp, input logic pc);
    start = 1; prog_len = (ADDR_W+1)'(len); loop_mode = lp; paced = pc;
    step();
    start = 0;
  endtask

  function automatic vec_t mk(input logic s, input int pl, input logic sp, input logic [31:0] ei,
                              input int ex, input logic eb, input logic ed, input logic ea);
    vec_t v;
    v.start = s; v.plen = (ADDR_W+1)'(pl); v.stop = sp; v.e_instr = ei;
    v.e_idx = ADDR_W'(ex); v.e_busy = eb; v.e_done = ed; v.e_ab = ea;
    return v;
  endfunction

  // Reference: position = advances so far (k/HOLD when timed, fetch pulses when paced),
  // wrapped modulo L in loop mode; one-shot completes once advances reach L.
  task automatic run_model(input int plen, input logic lp, input logic pc, input int ncyc,
                           input int stop_at, input int ld_at);
    int L, pulses, phase, a;
    logic [31:0] e_instr;
    int e_idx;
    logic e_busy, e_done, e_ab, tv_exp;
    logic [31:0] td_exp;
    int ti_exp;
    L = (plen > DEPTH) ? DEPTH : plen;
    pulses = 0; phase = (L == 0) ? 2 : 0;
    tv_exp = 0; td_exp = 0; ti_exp = 0;
    idle_in();
    do_start(plen, lp, pc);
    loop_mode = 1'($urandom); paced = 1'($urandom);
    for (int k = 0; k < ncyc; k++) begin
      e_instr = NOP; e_idx = 0; e_busy = 0; e_done = 0; e_ab = 0;
      if (phase == 0) begin
        a = pc ? pulses : k / HOLD;
        if (!lp && a >= L) begin e_done = 1; phase = 2; end
        else begin e_busy = 1; e_idx = a % L; e_instr = mem[a % L]; end
      end else if (phase == 1) begin
        e_ab = 1; phase = 2;
      end
      chk_core($sformatf("rm L%0d k%0d", plen, k), e_instr, e_idx, e_busy, e_done, e_ab);
      chk($sformatf("rm.tvalid k%0d", k), 32'(trace_valid), 32'(tv_exp));
      if (tv_exp) begin
        chk($sformatf("rm.tdata k%0d", k), trace_data, td_exp);
        chk($sformatf("rm.tidx k%0d", k), 32'(trace_idx), 32'(ti_exp));
      end
      en_fetch_pulse = ($urandom_range(0, 2) == 0);
      en_exe_pulse   = 1'($urandom_range(0, 1));
      result         = $urandom;
      stop           = (k == stop_at);
      load_en        = (k == ld_at) && e_busy;
      load_addr      = ADDR_W'(k % DEPTH);
      load_data      = $urandom;
      tv_exp = en_exe_pulse && e_busy; td_exp = result; ti_exp = e_idx;
      if (stop && e_busy) phase = 1;
      else if (e_busy && pc && en_fetch_pulse) pulses++;
      step();
    end
    idle_in();
    stop = 1; step(); stop = 0; step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] w [4];
    int e;
    w[0] = 32'h78800003; w[1] = 32'h79000004; w[2] = 32'h11890000; w[3] = 32'h2A100001;

    // reset values
    #2 reset = 0; #1;
    chk_reset("reset");
    step(); step();
    reset = 1;

    for (int i = 0; i < 4; i++) load(i, w[i]);

    // vector table: ignored start, idle stop, timed one-shot, done, idle
    tv.push_back(mk(1, 0, 0, NOP, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, NOP, 0, 0, 0, 0));
    tv.push_back(mk(1, 4, 0, w[0], 0, 1, 0, 0));
    for (int k = 1; k < 16; k++) tv.push_back(mk(0, 0, 0, w[k/4], k/4, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, NOP, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, NOP, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, NOP, 0, 0, 0, 0));
    idle_in();
    foreach (tv[i]) begin
      start = tv[i].start; prog_len = tv[i].plen; stop = tv[i].stop;
      step();
      chk_core($sformatf("vec%0d", i), tv[i].e_instr, int'(tv[i].e_idx),
               tv[i].e_busy, tv[i].e_done, tv[i].e_ab);
    end
    idle_in();

    // paced loop, fetch pulse every 5 cycles
    load(0, 32'h52990000); load(1, 32'hC0000002);
    do_start(2, 1, 1);
    e = 0;
    chk_core("paced_start", mem[0], 0, 1, 0, 0);
    for (int p = 0; p < 6; p++) begin
      for (int j = 0; j < 4; j++) begin
        step();
        chk_core("paced_hold", mem[e], e, 1, 0, 0);
      end
      en_fetch_pulse = 1; step(); en_fetch_pulse = 0;
      e = 1 - e;
      chk_core("paced_adv", mem[e], e, 1, 0, 0);
    end
    stop = 1; step(); stop = 0;
    chk_core("paced_stop", NOP, 0, 0, 0, 1);
    step();
    chk_core("paced_after", NOP, 0, 0, 0, 0);

    // stop in the same cycle as a timed advance
    do_start(4, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_core("abort_pre", mem[0], 0, 1, 0, 0);
    end
    stop = 1; step(); stop = 0;
    chk_core("abort", NOP, 0, 0, 0, 1);
    step();
    chk_core("abort_after", NOP, 0, 0, 0, 0);

    // trace capture at idx 2, and a pulse coinciding with an advance
    do_start(4, 0, 0);
    repeat (8) step();
    chk_core("trace_pre", mem[2], 2, 1, 0, 0);
    en_exe_pulse = 1; result = 32'h0000002A; step(); en_exe_pulse = 0;
    chk("trace.valid", 32'(trace_valid), 32'h1);
    chk("trace.data", trace_data, 32'h0000002A);
    chk("trace.idx", 32'(trace_idx), 32'h2);
    step();
    chk("trace.valid_drop", 32'(trace_valid), 32'h0);
    step();
    en_exe_pulse = 1; result = 32'h00000055; step(); en_exe_pulse = 0;
    chk("trace_adv.data", trace_data, 32'h00000055);
    chk("trace_adv.idx", 32'(trace_idx), 32'h2);
    chk("trace_adv.instr_idx", 32'(instr_idx), 32'h3);
    repeat (4) step();
    chk_core("trace_done", NOP, 0, 0, 1, 0);
    step();
    idle_in();

    // asynchronous reset mid-replay, then replay from entry 0
    do_start(4, 0, 0);
    en_exe_pulse = 1; result = 32'h00001234; step(); en_exe_pulse = 0;
    step();
    #2 reset = 0; #1;
    chk_reset("async_reset");
    step();
    reset = 1;
    run_model(4, 0, 0, 20, -1, -1);

    // boundaries: zero length, over-long length, load during replay
    run_model(0, 0, 0, 6, -1, -1);
    run_model(31, 0, 0, DEPTH*HOLD + 4, -1, -1);
    run_model(4, 0, 0, 20, -1, 3);
    run_model(4, 0, 0, 20, -1, -1);

    // randomized programs and modes
    for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    for (int r = 0; r < 14; r++) begin
      run_model($urandom_range(0, 20), 1'($urandom), 1'($urandom), 70,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1,
                $urandom_range(0, 30));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Synthesisable, parametrised instruction stimulus engine that sits in front of the multi-cycle CPU's `Instruction` input. It holds a small programmable instruction store and replays the program into the CPU, either for a fixed number of cycles per word or paced by the CPU's fetch pulse. It supports one-shot and looping replay and captures one CPU result word per executed instruction. It replaces hand-timed instruction sequences in simulation and enables on-board self-test.

## Interface
Parameters:
- `DATA_W`, 32: instruction and result width.
- `DEPTH`, 16: instruction store entries, ≥2.
- `ADDR_W`, `$clog2(DEPTH)`: store index width.
- `HOLD_CYCLES`, 4: cycles each word is presented in timed pacing, ≥1.
- `NOP_WORD`, 32'h00000000: value driven on `Instruction` when not replaying.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = reset.
- `load_en`  in  1  write one store entry.
- `load_addr`  in  ADDR_W  store write index.
- `load_data`  in  DATA_W  store write data.
- `prog_len`  in  ADDR_W+1  number of words to replay; sampled on start.
- `start`  in  1  begin replay; single-cycle request.
- `stop`  in  1  abort replay.
- `loop_mode`  in  1  sampled on start; 0 = one-shot, 1 = wrap to entry 0.
- `paced`  in  1  sampled on start; 0 = timed (HOLD_CYCLES), 1 = advance on `en_fetch_pulse`.
- `en_fetch_pulse`  in  1  CPU fetch strobe.
- `en_exe_pulse`  in  1  CPU execute strobe.
- `result`  in  DATA_W  CPU result to capture (e.g. `read_value2`).
- `Instruction`  out  DATA_W  word presented to the CPU.
- `instr_idx`  out  ADDR_W  index of the word currently presented.
- `busy`  out  1  replay in progress.
- `done`  out  1  one-cycle pulse on normal one-shot completion.
- `aborted`  out  1  one-cycle pulse when `stop` ends a replay.
- `trace_valid`  out  1  one-cycle pulse; trace outputs are valid.
- `trace_data`  out  DATA_W  captured `result`.
- `trace_idx`  out  ADDR_W  `instr_idx` at capture time.

## Operation
- States: IDLE, HOLD, DONE.
- Reset (any state, asynchronous): state IDLE; `Instruction`=NOP_WORD; `instr_idx`=0; `busy`, `done`, `aborted`, `trace_valid`=0; `trace_data`=0; `trace_idx`=0; hold counter 0. Store contents are not reset.
- IDLE: `load_en` writes `load_data` to `load_addr`. `start` with effective length L = min(`prog_len`, DEPTH) ≥ 1 latches L, `loop_mode` and `paced`, then enters HOLD with `instr_idx`=0 and `Instruction`=store[0]. A `start` with L=0 is ignored.
- HOLD: `busy`=1; `load_en` and `start` are ignored.
  - Advance event, timed: hold counter reaches HOLD_CYCLES-1.
  - Advance event, paced: `en_fetch_pulse`=1.
  - On advance with idx<L-1: idx+1; `Instruction`=store[idx+1]; counter cleared.
  - On advance with idx=L-1 and loop_mode=1: idx=0; `Instruction`=store[0].
  - On advance with idx=L-1 and loop_mode=0: go to DONE.
- DONE, one cycle: `done`=1, `Instruction`=NOP_WORD, `busy`=0; then IDLE.
- `stop` in HOLD: takes priority over the advance event. Next cycle: IDLE, `Instruction`=NOP_WORD, `aborted`=1, `busy`=0, no `done`. `stop` in IDLE or DONE has no effect.
- Trace capture: `en_exe_pulse`=1 while `busy`=1 produces `trace_valid`=1 next cycle, with `trace_data`=`result` and `trace_idx`=`instr_idx` sampled in the pulse cycle. A pulse arriving in the same cycle as an advance captures the pre-advance index.

## Timing
- Start to first word: 1 cycle. `start` at edge n gives `Instruction`=store[0] after edge n.
- Timed pacing: each word is held exactly HOLD_CYCLES cycles. One-shot total is L×HOLD_CYCLES cycles of `busy`, then 1 DONE cycle.
- Paced pacing: a word changes on the edge after the `en_fetch_pulse` cycle. Back-to-back pulses advance once per cycle.
- Store write: 1-cycle latency. An entry written at edge n can be started at edge n+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `instr_seq_pkg`: state enum, NOP_WORD default, and instruction field constants (opcode[31:27], Rd/Rs/Rt 4-bit fields) for bench decoding.
- One sub-module, `instr_store`: DEPTH×DATA_W single-write, single-read register array, with no reset.

## Test plan
- Timed one-shot: load 78800003, 79000004, 11890000, 2A100001; HOLD_CYCLES=4; start with prog_len=4 → each word is held 4 cycles in order; `busy` is high for 16 cycles; then `done` for 1 cycle; then `Instruction`=00000000.
- Paced loop: prog_len=2, words 52990000 and C0000002, paced=1, loop_mode=1; `en_fetch_pulse` every 5 cycles → output alternates between the two words one cycle after each pulse; `instr_idx` wraps 1→0; `done` is never asserted.
- Abort: `stop` asserted in the same cycle as an advance → next cycle `aborted`=1, `Instruction`=NOP, `instr_idx`=0, no `done`.
- Boundaries: prog_len=0 start → ignored, `busy` stays 0. prog_len=31 with DEPTH=16 → 16 words replayed. `load_en` during replay → store unchanged, verified by a second replay.
- Trace: `en_exe_pulse` with `result`=0000002A while idx=2 → next cycle `trace_valid`=1, `trace_data`=0000002A, `trace_idx`=2.
- Reset mid-replay: `reset`=0 asynchronously during HOLD → outputs return to reset values immediately, without waiting for a clock edge; store contents are retained; the next start replays from entry 0.
